// File: rtl/aes_pkg.sv
// aes_pkg: shared AES key-schedule constants, S-box lookup, xtime and FSM encoding.
package aes_pkg;
  localparam logic [7:0] RCON_INIT = 8'h01;
  localparam logic [7:0] RCON_POLY = 8'h1B;
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };
  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[8*(255-int'(b)) +: 8];
  endfunction
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
  endfunction
  // Only the three FIPS-197 key sizes are legal, each tied to its round count.
  function automatic bit aes_pair_ok(input int nr, input int nk);
    return (nk == 4 || nk == 6 || nk == 8) && nr == nk + 6;
  endfunction
endpackage

// File: rtl/aes_sub_word.sv
// aes_sub_word: combinational SubWord, four parallel S-box byte lookups.
module aes_sub_word
  import aes_pkg::*;
(
  input  logic [31:0] word,
  output logic [31:0] sub
);
  for (genvar b = 0; b < 4; b++) begin : g_byte
    assign sub[8*b +: 8] = sbox(word[8*b +: 8]);
  end
endmodule

// File: rtl/aes_key_expander.sv
// aes_key_expander: iterative one-word-per-cycle AES key schedule with a shared SubWord.
// Optional registered round-key read port enabled by AES_KEY_RD_PORT_EN.
module aes_key_expander
  import aes_pkg::*;
#(
  parameter int NR = 14,
  parameter int NK = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [32*NK-1:0]       key_in,
`ifdef AES_KEY_RD_PORT_EN
  input  logic [3:0]             rd_round,
  output logic [127:0]           rd_key,
`endif
  output logic                   busy,
  output logic                   keys_valid,
  output logic [128*(NR+1)-1:0]  round_keys
);
  localparam int TOTAL = 4 * (NR + 1);
  localparam int IW = $clog2(TOTAL + 1);
  if (!aes_pair_ok(NR, NK)) begin : g_bad_pair
    $error("aes_key_expander: illegal NR/NK pairing");
  end
  state_t state;
  logic [31:0] w [TOTAL];
  logic [IW-1:0] idx;
  logic [2:0] mod;
  logic [7:0] rcon;
  logic [IW-1:0] prev_i, old_i;
  logic [31:0] prev, sub_in, sub_out, temp;
  assign prev_i = idx - 1'b1;
  assign old_i = idx - IW'(NK);
  assign prev = w[prev_i];
  assign sub_in = (mod == 3'd0) ? {prev[23:0], prev[31:24]} : prev;
  aes_sub_word u_sub (.word(sub_in), .sub(sub_out));
  always_comb
    temp = (mod == 3'd0) ? sub_out ^ {rcon, 24'h0} :
           (NK == 8 && mod == 3'd4) ? sub_out : prev;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      busy <= 1'b0;
      keys_valid <= 1'b0;
      idx <= '0;
      mod <= '0;
      rcon <= '0;
      for (int i = 0; i < TOTAL; i++) w[i] <= '0;
    end else if (state == EXPAND) begin
      w[idx] <= w[old_i] ^ temp;
      idx <= idx + 1'b1;
      mod <= (mod == 3'(NK - 1)) ? 3'd0 : mod + 3'd1;
      if (mod == 3'd0) rcon <= xtime(rcon);
      if (idx == IW'(TOTAL - 1)) begin
        state <= DONE;
        busy <= 1'b0;
        keys_valid <= 1'b1;
      end
    end else if (start) begin
      for (int i = 0; i < NK; i++) w[i] <= key_in[32*(NK-1-i) +: 32];
      idx <= IW'(NK);
      mod <= '0;
      rcon <= RCON_INIT;
      keys_valid <= 1'b0;
      busy <= 1'b1;
      state <= EXPAND;
    end
  for (genvar r = 0; r <= NR; r++) begin : g_rk
    assign round_keys[128*r +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  end
`ifdef AES_KEY_RD_PORT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rd_key <= '0;
    else rd_key <= (rd_round > 4'(NR)) ? 128'h0 : round_keys[128*rd_round +: 128];
`endif
endmodule

// File: tb/tb_aes_key_expander.sv
// tb_aes_key_expander: directed scoreboard bench for AES-128 and AES-256 instances.
module tb_aes_key_expander;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_a, rst_b, start_a, start_b, busy_a, kv_a, busy_b, kv_b;
  logic [127:0] key_a;
  logic [255:0] key_b;
  logic [1407:0] rk_a;
  logic [1919:0] rk_b;
`ifdef AES_KEY_RD_PORT_EN
  logic [3:0] rd_round_a, rd_round_b;
  logic [127:0] rd_key_a, rd_key_b;
`endif
  aes_key_expander #(.NR(10), .NK(4)) dut_a (
    .clk(clk), .rst_n(rst_a), .start(start_a), .key_in(key_a),
`ifdef AES_KEY_RD_PORT_EN
    .rd_round(rd_round_a), .rd_key(rd_key_a),
`endif
    .busy(busy_a), .keys_valid(kv_a), .round_keys(rk_a));
  aes_key_expander dut_b (
    .clk(clk), .rst_n(rst_b), .start(start_b), .key_in(key_b),
`ifdef AES_KEY_RD_PORT_EN
    .rd_round(rd_round_b), .rd_key(rd_key_b),
`endif
    .busy(busy_b), .keys_valid(kv_b), .round_keys(rk_b));
  localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K1_RK1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] K1_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [255:0] K2 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  typedef struct packed {logic [3:0] r; logic [127:0] v;} exp_t;
  exp_t sb[$];
  int compared = 0, mismatched = 0;
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic push(input int r, input logic [127:0] v);
    sb.push_back({4'(r), v});
  endtask
  task automatic run_a(input logic [127:0] key, input bit noise);
    int n;
    exp_t e;
    @(posedge clk); #1 key_a = key; start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0; key_a = ~key;
    check("busy_after_start", 128'(busy_a), 128'd1);
    check("kv_low_at_start", 128'(kv_a), 128'd0);
    n = 0;
    while (!kv_a && n < 100) begin
      start_a = noise && (n == 4 || n == 19);
      @(posedge clk); #1 n++;
    end
    start_a = 1'b0;
    check("latency_a", 128'(n), 128'd40);
    check("busy_done_a", 128'(busy_a), 128'd0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check($sformatf("rk_a[%0d]", e.r), rk_a[128*e.r +: 128], e.v);
    end
  endtask
  initial begin
    int n;
    exp_t e;
    rst_a = 1'b0; rst_b = 1'b0; start_a = 1'b0; start_b = 1'b0; key_a = '0; key_b = '0;
`ifdef AES_KEY_RD_PORT_EN
    rd_round_a = '0; rd_round_b = '0;
`endif
    repeat (3) @(posedge clk);
    #1 check("reset_busy", 128'(busy_a), 128'd0);
    check("reset_kv", 128'(kv_a), 128'd0);
    check("reset_store", 128'(rk_a == '0), 128'd1);
    rst_a = 1'b1; rst_b = 1'b1;
    push(1, K1_RK1); push(10, K1_RK10); push(0, K1);
    run_a(K1, 1'b0);
    check("w4", 128'(rk_a[128+96 +: 32]), 128'h0a0fafe17);
    push(1, K1_RK1); push(10, K1_RK10);
    run_a(K1, 1'b1);
    @(posedge clk); #1 key_a = K1; start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    repeat (15) @(posedge clk);
    #2 rst_a = 1'b0;
    #1 check("abort_busy", 128'(busy_a), 128'd0);
    check("abort_kv", 128'(kv_a), 128'd0);
    check("abort_store", 128'(rk_a == '0), 128'd1);
    @(posedge clk); #1 rst_a = 1'b1;
    push(10, K1_RK10); push(1, K1_RK1);
    run_a(K1, 1'b0);
`ifdef AES_KEY_RD_PORT_EN
    rd_round_a = 4'd10;
    @(posedge clk); #1 check("rd_key_r10", rd_key_a, K1_RK10);
    rd_round_a = 4'd12;
    @(posedge clk); #1 check("rd_key_r12", rd_key_a, 128'h0);
`endif
    push(0, 128'h0);
    push(1, 128'h62636363626363636263636362636363);
    push(10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    run_a(128'h0, 1'b0);
    push(0, K2[255:128]); push(1, K2[127:0]); push(14, 128'hfe4890d1e6188d0b046df344706c631e);
    @(posedge clk); #1 key_b = K2; start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0; key_b = '0;
    check("busy_b", 128'(busy_b), 128'd1);
    n = 0;
    while (!kv_b && n < 100) begin
      @(posedge clk); #1 n++;
    end
    check("latency_b", 128'(n), 128'd52);
    check("w8", 128'(rk_b[256+96 +: 32]), 128'h09ba35411);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check($sformatf("rk_b[%0d]", e.r), rk_b[128*e.r +: 128], e.v);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
